// File: rtl/requant_sequencer.sv
// requant_sequencer
//
// Streams signed 32-bit accumulators from the MAC array drain through a
// per-channel requantizer and emits int8 activations. Each accepted sample is
// tagged with a running channel index that selects MULT/SHIFT from an internal
// table, and travels with its in_last flag.
//
// Pipeline (all registers advance together on en):
//   s1  : product = acc * MULT[ch]   (signed 32x32 -> 64), SHIFT/ch/last latched
//   s2  : round-half-up arithmetic right shift by SHIFT
//   s3  : saturate to int8 (or [0,127] with fused ReLU)
//   out : output register
// Accept at edge N -> out_valid after edge N+3, one sample per cycle.
//
// Handshake: a transfer happens on an edge where valid and ready are both high
// on the same side. en = ~out_valid | out_ready; in_ready = en (gated while the
// internal reset is still asserted). out_* hold while out_valid & ~out_ready.
// There is no combinational path from in_valid to out_valid.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   in_valid/in_ready      accumulator input handshake
//   in_acc[31:0]           signed accumulator
//   in_last                last sample of frame (channel counter returns to 0)
//   out_valid/out_ready    int8 output handshake
//   out_q[7:0]             signed int8 result
//   out_ch[CH_W-1:0]       channel index of out_q
//   out_last               in_last carried with its sample
//   cfg_we/cfg_addr        table write strobe / entry
//   cfg_mult[31:0]         signed multiplier
//   cfg_shift[5:0]         right shift 0..63
//   busy                   any pipeline register holds valid data
//
// Build option: define REQUANT_RELU_EN to clamp the lower bound to 0 (fused
// ReLU). Ports are the same in both builds.

module requant_sequencer #(
  parameter int NUM_CH = 16,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_acc,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_q,
  output logic [CH_W-1:0] out_ch,
  output logic            out_last,
  input  logic            cfg_we,
  input  logic [CH_W-1:0] cfg_addr,
  input  logic [31:0]     cfg_mult,
  input  logic [5:0]      cfg_shift,
  output logic            busy
);

  localparam bit FULL_TABLE = (NUM_CH == (1 << CH_W));
  localparam logic signed [63:0] SAT_HI = 64'sd127;
`ifdef REQUANT_RELU_EN
  localparam logic signed [63:0] SAT_LO = 64'sd0;
`else
  localparam logic signed [63:0] SAT_LO = -64'sd128;
`endif

  // ---------------------------------------------------------------------------
  // Reset synchronizer: assertion is immediate, release is aligned to clk.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic signed [31:0] mult_q  [NUM_CH];
  logic signed [31:0] mult_d  [NUM_CH];
  logic [5:0]         shift_q [NUM_CH];
  logic [5:0]         shift_d [NUM_CH];

  logic [CH_W-1:0]    ch_q, ch_d;

  logic               s1_valid_q, s1_valid_d;
  logic signed [63:0] s1_prod_q,  s1_prod_d;
  logic [5:0]         s1_shift_q, s1_shift_d;
  logic [CH_W-1:0]    s1_ch_q,    s1_ch_d;
  logic               s1_last_q,  s1_last_d;

  logic               s2_valid_q, s2_valid_d;
  logic signed [63:0] s2_r_q,     s2_r_d;
  logic [CH_W-1:0]    s2_ch_q,    s2_ch_d;
  logic               s2_last_q,  s2_last_d;

  logic               s3_valid_q, s3_valid_d;
  logic [7:0]         s3_q_q,     s3_q_d;
  logic [CH_W-1:0]    s3_ch_q,    s3_ch_d;
  logic               s3_last_q,  s3_last_d;

  logic               out_valid_q, out_valid_d;
  logic [7:0]         out_q_q,     out_q_d;
  logic [CH_W-1:0]    out_ch_q,    out_ch_d;
  logic               out_last_q,  out_last_d;

  // ---------------------------------------------------------------------------
  // Handshake and control
  // ---------------------------------------------------------------------------
  logic en;
  logic accept;
  logic busy_int;
  logic addr_ok;
  logic cfg_wr_en;

  assign en       = ~out_valid_q | out_ready;
  assign in_ready = en & rst_int_n;
  assign accept   = in_valid & in_ready;
  assign busy_int = s1_valid_q | s2_valid_q | s3_valid_q | out_valid_q;

  always_comb begin
    addr_ok = 1'b1;
    if (!FULL_TABLE) begin
      addr_ok = ({{(32-CH_W){1'b0}}, cfg_addr} < 32'(NUM_CH));
    end
  end

  // A table write is only safe when nothing in flight or being accepted could
  // observe a half-updated entry; otherwise it is silently dropped.
  assign cfg_wr_en = cfg_we & ~busy_int & ~accept & addr_ok;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic signed [63:0] acc_ext;
  logic signed [63:0] mult_ext;
  logic signed [63:0] prod;
  logic signed [63:0] bias;
  logic signed [63:0] round_r;
  logic [7:0]         sat_q;

  // Stage 1: table lookup with the entry in force at the acceptance edge.
  always_comb begin
    acc_ext  = {{32{in_acc[31]}}, in_acc};
    mult_ext = {{32{mult_q[ch_q][31]}}, mult_q[ch_q]};
    prod     = acc_ext * mult_ext;
  end

  // Stage 2: adding half an LSB before the arithmetic shift rounds ties toward
  // +inf (e.g. -3 >> 1 -> -1, 3 >> 1 -> 2).
  always_comb begin
    bias    = 64'sd0;
    round_r = s1_prod_q;
    if (s1_shift_q != 6'd0) begin
      bias    = 64'sd1 <<< (s1_shift_q - 6'd1);
      round_r = (s1_prod_q + bias) >>> s1_shift_q;
    end
  end

  // Stage 3: clamp to the int8 range (or [0,127] in the ReLU build).
  always_comb begin
    if (s2_r_q > SAT_HI)      sat_q = SAT_HI[7:0];
    else if (s2_r_q < SAT_LO) sat_q = SAT_LO[7:0];
    else                      sat_q = s2_r_q[7:0];
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    mult_d  = mult_q;
    shift_d = shift_q;
    if (cfg_wr_en) begin
      mult_d[cfg_addr]  = cfg_mult;
      shift_d[cfg_addr] = cfg_shift;
    end
  end

  always_comb begin
    ch_d = ch_q;
    if (accept) begin
      if (in_last || (ch_q == CH_W'(NUM_CH - 1))) ch_d = '0;
      else                                        ch_d = ch_q + 1'b1;
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_prod_d   = s1_prod_q;
    s1_shift_d  = s1_shift_q;
    s1_ch_d     = s1_ch_q;
    s1_last_d   = s1_last_q;
    s2_valid_d  = s2_valid_q;
    s2_r_d      = s2_r_q;
    s2_ch_d     = s2_ch_q;
    s2_last_d   = s2_last_q;
    s3_valid_d  = s3_valid_q;
    s3_q_d      = s3_q_q;
    s3_ch_d     = s3_ch_q;
    s3_last_d   = s3_last_q;
    out_valid_d = out_valid_q;
    out_q_d     = out_q_q;
    out_ch_d    = out_ch_q;
    out_last_d  = out_last_q;

    if (en) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_prod_d  = prod;
        s1_shift_d = shift_q[ch_q];
        s1_ch_d    = ch_q;
        s1_last_d  = in_last;
      end

      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_r_d    = round_r;
        s2_ch_d   = s1_ch_q;
        s2_last_d = s1_last_q;
      end

      s3_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        s3_q_d    = sat_q;
        s3_ch_d   = s2_ch_q;
        s3_last_d = s2_last_q;
      end

      // Payload only reloads from a valid stage so a bubble leaves the last
      // result visible but out_valid low.
      out_valid_d = s3_valid_q;
      if (s3_valid_q) begin
        out_q_d    = s3_q_q;
        out_ch_d   = s3_ch_q;
        out_last_d = s3_last_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        mult_q[i]  <= 32'sd1;
        shift_q[i] <= 6'd0;
      end
    end else begin
      mult_q  <= mult_d;
      shift_q <= shift_d;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      ch_q        <= '0;
      s1_valid_q  <= 1'b0;
      s1_prod_q   <= '0;
      s1_shift_q  <= '0;
      s1_ch_q     <= '0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_r_q      <= '0;
      s2_ch_q     <= '0;
      s2_last_q   <= 1'b0;
      s3_valid_q  <= 1'b0;
      s3_q_q      <= '0;
      s3_ch_q     <= '0;
      s3_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_q_q     <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
    end else begin
      ch_q        <= ch_d;
      s1_valid_q  <= s1_valid_d;
      s1_prod_q   <= s1_prod_d;
      s1_shift_q  <= s1_shift_d;
      s1_ch_q     <= s1_ch_d;
      s1_last_q   <= s1_last_d;
      s2_valid_q  <= s2_valid_d;
      s2_r_q      <= s2_r_d;
      s2_ch_q     <= s2_ch_d;
      s2_last_q   <= s2_last_d;
      s3_valid_q  <= s3_valid_d;
      s3_q_q      <= s3_q_d;
      s3_ch_q     <= s3_ch_d;
      s3_last_q   <= s3_last_d;
      out_valid_q <= out_valid_d;
      out_q_q     <= out_q_d;
      out_ch_q    <= out_ch_d;
      out_last_q  <= out_last_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_valid = out_valid_q;
  assign out_q     = out_q_q;
  assign out_ch    = out_ch_q;
  assign out_last  = out_last_q;
  assign busy      = busy_int;

endmodule

// File: tb/tb_requant_sequencer.sv
// Self-checking bench for requant_sequencer. A reference model tracks the
// config table, channel counter and in-flight count; every accepted sample
// pushes its expected {last, ch, q} into exp_q and a separate monitor pops and
// compares on each output transfer.

module tb_requant_sequencer;

  localparam int NUM_CH = 16;
  localparam int CH_W   = 4;
  localparam int W      = 1 + CH_W + 8;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_acc;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [7:0]      out_q;
  logic [CH_W-1:0] out_ch;
  logic            out_last;
  logic            cfg_we;
  logic [CH_W-1:0] cfg_addr;
  logic [31:0]     cfg_mult;
  logic [5:0]      cfg_shift;
  logic            busy;

  requant_sequencer #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_acc    (in_acc),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_ch    (out_ch),
    .out_last  (out_last),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_mult  (cfg_mult),
    .cfg_shift (cfg_shift),
    .busy      (busy)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  longint       m_mult  [NUM_CH];
  int           m_shift [NUM_CH];
  int           m_ch;
  int           in_flight;
  bit           rand_ready;
  int           n_checks;
  int           n_fails;
  bit           stalled;
  logic [W-1:0] held;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Requantize by plain integer arithmetic: floor((p + d/2) / d), d = 2^sh.
  function automatic logic [7:0] ref_q(input longint acc, input longint mult, input int sh);
    longint p, d, num, r, lo;
    p = acc * mult;
    if (sh == 0) begin
      r = p;
    end else begin
      d   = longint'(1) <<< sh;
      num = p + d / 2;
      r   = num / d;
      if (num < 0 && (num % d) != 0) r = r - 1;
    end
`ifdef REQUANT_RELU_EN
    lo = 0;
`else
    lo = -128;
`endif
    if (r > 127) r = 127;
    if (r < lo)  r = lo;
    return r[7:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_mult[i]  = 1;
      m_shift[i] = 0;
    end
    m_ch      = 0;
    in_flight = 0;
    exp_q.delete();
  endtask

  // Model side: decides transfers that will happen at the next rising edge.
  always @(negedge clk) begin
    bit acc_now, out_now;
    if (!rst_n) begin
      model_reset();
    end else begin
      check("busy", longint'(busy), longint'(in_flight != 0));
      acc_now = in_valid & in_ready;
      out_now = out_valid & out_ready;
      if (acc_now) begin
        exp_q.push_back({in_last, 4'(m_ch),
                         ref_q(longint'($signed(in_acc)), m_mult[m_ch], m_shift[m_ch])});
        if (in_last || m_ch == NUM_CH - 1) m_ch = 0;
        else                               m_ch = m_ch + 1;
      end
      if (cfg_we && in_flight == 0 && !acc_now && int'(cfg_addr) < NUM_CH) begin
        m_mult[cfg_addr]  = longint'($signed(cfg_mult));
        m_shift[cfg_addr] = int'(cfg_shift);
      end
      in_flight = in_flight + int'(acc_now) - int'(out_now);
    end
  end

  // Monitor: pops on output transfers, checks stability while stalled.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", longint'(out_valid), 1);
        check("stall_hold", longint'({out_last, out_ch, out_q}), longint'(held));
      end
      if (out_valid && !out_ready) check("in_ready_stall", longint'(in_ready), 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_q", longint'($signed(out_q)), longint'($signed(e[7:0])));
          check("out_ch", longint'(out_ch), longint'(e[CH_W+7:8]));
          check("out_last", longint'(out_last), longint'(e[W-1]));
        end
      end
      stalled = out_valid & ~out_ready;
      held    = {out_last, out_ch, out_q};
    end
  end

  // Downstream ready: always-on or 50% random.
  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at posedge+1, return at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] acc, input logic last);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_acc   = acc;
    in_last  = last;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 200) begin
        check("send_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic cfg_write(input int addr, input logic [31:0] mult, input int sh);
    cfg_we    = 1'b1;
    cfg_addr  = 4'(addr);
    cfg_mult  = mult;
    cfg_shift = 6'(sh);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_flight != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 3000) check("drain_timeout", 1, 0);
    idle(2);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_out_q", longint'(out_q), 0);
    check("rst_out_ch", longint'(out_ch), 0);
    check("rst_out_last", longint'(out_last), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int k;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_acc     = '0;
    in_last    = 1'b0;
    out_ready  = 1'b1;
    cfg_we     = 1'b0;
    cfg_addr   = '0;
    cfg_mult   = '0;
    cfg_shift  = '0;
    rand_ready = 1'b0;
    n_checks   = 0;
    n_fails    = 0;
    stalled    = 1'b0;
    model_reset();
    idle(2);
    do_reset();

    // Identity table, first sample latency then back-to-back saturation.
    send(32'sd5, 1'b0);
    k = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (out_valid) begin
        k = i;
        break;
      end
    end
    check("latency", k, 4);
    @(posedge clk);
    #1;
    send(-32'sd7, 1'b0);
    send(32'sd200, 1'b0);
    send(-32'sd300, 1'b0);
    drain();

    // Rounding: ch1 MULT=1 SHIFT=1, ch2 MULT=3 SHIFT=2.
    cfg_write(1, 32'sd1, 1);
    cfg_write(2, 32'sd3, 2);
    send(32'sd0, 1'b1);
    send(32'sd9, 1'b0);
    send(32'sd3, 1'b0);
    send(32'sd10, 1'b0);
    send(32'sd1, 1'b1);
    send(32'sd7, 1'b0);
    send(-32'sd3, 1'b0);
    send(32'sd0, 1'b1);
    drain();

    // Channel wrap, then in_last on the 6th of 20.
    for (int i = 0; i < 20; i++) send(32'(i), 1'b0);
    send(32'sd0, 1'b1);
    for (int i = 0; i < 20; i++) send(32'(i - 10), (i == 5));
    send(32'sd0, 1'b1);
    drain();

    // Config while busy is dropped; idle config is applied.
    send(32'sd100, 1'b1);
    cfg_write(0, 32'sd7, 0);
    drain();
    send(32'sd10, 1'b1);
    drain();
    cfg_write(0, 32'sd7, 0);
    send(32'sd10, 1'b1);
    drain();
    in_valid = 1'b1; in_acc = 32'sd3; in_last = 1'b1;
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_mult = 32'sd2; cfg_shift = 6'd0;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0; cfg_we = 1'b0;
    drain();
    send(32'sd3, 1'b1);
    drain();

    // Reset mid-stream: in-flight samples dropped, table back to identity.
    for (int i = 0; i < 3; i++) send(32'sd50, 1'b0);
    do_reset();
    send(32'sd5, 1'b0);
    send(32'sd3, 1'b0);
    drain();

    // Random table, random accumulators, 50% downstream backpressure.
    for (int c = 0; c < NUM_CH; c++) begin
      cfg_write(c, ($urandom_range(0, 3) == 0) ? 32'($urandom)
                                              : 32'($signed($urandom_range(0, 400)) - 200),
                $urandom_range(0, 40));
    end
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(($urandom_range(0, 3) == 0) ? 32'($urandom)
                                      : 32'($signed($urandom_range(0, 4000)) - 2000),
           ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();
    rand_ready = 1'b0;
    idle(2);

    // Saturation bounds on identity table (ReLU build clamps negatives to 0).
    do_reset();
    send(-32'sd50, 1'b0);
    send(32'sd500, 1'b0);
    send(-32'sd129, 1'b0);
    send(32'sd127, 1'b0);
    drain();

    check("queue_empty", longint'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
